mult_retire_q: RTL and testbench
================================

# mult_retire_q

Issue/retire wrapper around `pipe_mult`: accepts multiply requests over a valid/ready handshake, drives the multiplier's fixed-latency, non-stallable pipeline, tags each operation, and buffers products in an in-order result FIFO toward writeback. Credit accounting guarantees every issued product has a FIFO slot, so `pipe_mult` never needs to stall. Sits between the execute-stage issue logic (upstream) and `pipe_mult`/writeback (downstream).

## Interface
- `BIT_WIDTH`, 32, operand/product width
- `STAGES`, 8, `pipe_mult` latency in clock edges from enable to `done_o`
- `TAG_W`, 5, tag width (destination register id)
- `DEPTH`, 4, result FIFO depth; power of two, ≥1
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-low; shared with `pipe_mult`
- `req_valid_i`  in  1  request valid
- `req_ready_o`  out  1  request accepted this cycle when high with valid
- `req_a_i`, `req_b_i`  in  BIT_WIDTH  operands
- `req_tag_i`  in  TAG_W  request tag
- `mult_en_o`  out  1  to `pipe_mult.en`
- `mult_a_o`, `mult_b_o`  out  BIT_WIDTH  to `multiplier_i`/`multicand_i`
- `mult_product_i`  in  BIT_WIDTH  from `product_o`
- `mult_done_i`  in  1  from `done_o`
- `rsp_valid_o`  out  1  result valid
- `rsp_ready_i`  in  1  consumer ready
- `rsp_data_o`  out  BIT_WIDTH  product, low BIT_WIDTH bits
- `rsp_tag_o`  out  TAG_W  tag of result
- `err_o`  out  1  sticky tag/done misalignment flag

## Operation
- Accept = `req_valid_i & req_ready_o`; `mult_en_o` = accept (combinational); `mult_a_o`/`mult_b_o` = `req_a_i`/`req_b_i` pass-through.
- `inflight` counter: +1 on accept, −1 on `mult_done_i`; both in same cycle → unchanged.
- `req_ready_o` = rst high AND (`inflight + fifo_count` < DEPTH).
- Tag pipeline: STAGES registers of {valid, tag}; shift every cycle; head valid/tag aligned with `mult_done_i`/`mult_product_i`.
- On `mult_done_i` with head valid: write {product, head tag} to FIFO tail.
- `mult_done_i` ≠ head valid: set `err_o` (sticky until reset); stray product dropped, FIFO unchanged.
- FIFO: circular, read/write pointers wrap modulo DEPTH; `rsp_valid_o` = count ≠ 0; pop on `rsp_valid_o & rsp_ready_i`; simultaneous push/pop keeps count. Overflow impossible by credit rule.
- Results strictly in issue order.
- Arithmetic: product is unsigned low BIT_WIDTH bits (signed low bits identical).

## Timing
- Reset (rst low at edge): inflight, count, pointers, tag valids, `err_o` cleared. During/after reset: `req_ready_o`=0 while rst low, `mult_en_o`=0, `rsp_valid_o`=0, `err_o`=0, `rsp_data_o`/`rsp_tag_o` don't-care.
- Reset mid-operation: all in-flight and buffered results discarded; no response emerges for pre-reset requests.
- Latency (no bypass): accept at edge N → FIFO write at edge N+STAGES → `rsp_valid_o` high in cycle after edge N+STAGES.
- Throughput: one request/cycle sustained iff `rsp_ready_i` high and DEPTH ≥ STAGES+1; smaller DEPTH throttles `req_ready_o`.
- `rsp_ready_i` low: data/tag held stable while `rsp_valid_o` high.

## Configuration
- `MULT_RETIRE_BYPASS_EN` defined: when FIFO empty, head valid, `mult_done_i` high and `rsp_ready_i` high, product/tag presented combinationally on `rsp_*` that cycle and not written to FIFO; latency STAGES. Otherwise normal FIFO path; ordering preserved.
- Undefined: every result passes through FIFO; latency STAGES+1; no combinational path from `mult_*_i` to `rsp_*`.

## Test plan
- Single op: a=2, b=3, tag=5, `rsp_ready_i`=1 → `rsp_valid_o` one cycle, data 6, tag 5, at STAGES+1 cycles (STAGES with bypass).
- Wrap: a=0xFFFFFFFF, b=3, tag=1 → data 0xFFFFFFFD; a=−20, b=5 → 0xFFFFFF9C.
- Backpressure: `rsp_ready_i`=0, continuous valid tags 0.. → exactly DEPTH accepted, then `req_ready_o`=0; release → tags 0..DEPTH−1 drained in order, `req_ready_o` reasserts.
- Streaming: DEPTH=STAGES+1, 100 random back-to-back ops, `rsp_ready_i`=1 → `req_ready_o` never drops, all products match, tags in order.
- Reset mid-op: 3 ops in flight + 1 buffered, rst low one edge → `rsp_valid_o`=0, no later responses, `req_ready_o`=1 after release.
- Fault: force `mult_done_i`=1 with no request → `err_o`=1 next cycle and stays, FIFO count unchanged.

Source files
------------

// File: rtl/mult_retire_q.sv
// mult_retire_q: issue/retire wrapper around a fixed-latency, non-stallable multiplier.
// Requests are tagged on the way in, the tag rides a shadow pipeline that lines up with the
// multiplier's done/product, and results are queued in an in-order FIFO for writeback.
// A request is only accepted when a FIFO slot is guaranteed for its product, so the
// multiplier never has to stall.
// Optional feature: define MULT_RETIRE_BYPASS_EN to present a product directly on rsp_*
// in the cycle it completes when the FIFO is empty and the consumer is ready.
module mult_retire_q #(
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned STAGES    = 8,
    parameter int unsigned TAG_W     = 5,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [BIT_WIDTH-1:0] req_a_i,
    input  logic [BIT_WIDTH-1:0] req_b_i,
    input  logic [TAG_W-1:0]     req_tag_i,
    output logic                 mult_en_o,
    output logic [BIT_WIDTH-1:0] mult_a_o,
    output logic [BIT_WIDTH-1:0] mult_b_o,
    input  logic [BIT_WIDTH-1:0] mult_product_i,
    input  logic                 mult_done_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [BIT_WIDTH-1:0] rsp_data_o,
    output logic [TAG_W-1:0]     rsp_tag_o,
    output logic                 err_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Circular pointer advance, wrapping modulo DEPTH (DEPTH need not fill PTR_W).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + PTR_W'(1);
    endfunction

    // Shadow tag pipeline, one entry per multiplier stage.
    logic [STAGES-1:0] tag_vld_q;
    logic [TAG_W-1:0]  tag_q [STAGES];

    // Result FIFO storage and bookkeeping.
    logic [BIT_WIDTH-1:0] data_mem [DEPTH];
    logic [TAG_W-1:0]     tag_mem  [DEPTH];
    logic [PTR_W-1:0]     wptr_q, wptr_d;
    logic [PTR_W-1:0]     rptr_q, rptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [CNT_W-1:0]     inflight_q, inflight_d;
    logic                 err_q, err_d;

    logic             accept;
    logic             head_vld;
    logic [TAG_W-1:0] head_tag;
    logic             fifo_empty;
    logic             bypass;
    logic             push;
    logic             pop;
    logic             rsp_fire;
    logic             inflight_inc;
    logic             inflight_dec;
    logic [CNT_W:0]   credits_used;

    assign head_vld   = tag_vld_q[STAGES-1];
    assign head_tag   = tag_q[STAGES-1];
    assign fifo_empty = (count_q == '0);

`ifdef MULT_RETIRE_BYPASS_EN
    // Completing product skips the FIFO only when nothing older is waiting.
    assign bypass     = fifo_empty & head_vld & mult_done_i & rsp_ready_i;
    assign rsp_data_o = fifo_empty ? mult_product_i : data_mem[rptr_q];
    assign rsp_tag_o  = fifo_empty ? head_tag : tag_mem[rptr_q];
`else
    assign bypass     = 1'b0;
    assign rsp_data_o = data_mem[rptr_q];
    assign rsp_tag_o  = tag_mem[rptr_q];
`endif

    assign rsp_valid_o = rst & (~fifo_empty | bypass);
    assign rsp_fire    = rsp_valid_o & rsp_ready_i;
    assign pop         = rsp_fire & ~fifo_empty;
    assign push        = mult_done_i & head_vld & ~bypass;

    // A result leaving this cycle has already returned its credit; without this, a FIFO of
    // STAGES+1 entries could not sustain one request per cycle.
    assign credits_used = {1'b0, inflight_q} + {1'b0, count_q} - {{CNT_W{1'b0}}, rsp_fire};
    assign req_ready_o  = rst & (credits_used < (CNT_W + 1)'(DEPTH));

    assign accept    = req_valid_i & req_ready_o;
    assign mult_en_o = accept;
    assign mult_a_o  = req_a_i;
    assign mult_b_o  = req_b_i;
    assign err_o     = rst & err_q;

    // A stray done with nothing in flight must not wrap the credit counter.
    assign inflight_inc = accept;
    assign inflight_dec = mult_done_i & (inflight_q != '0);

    // Next-state for in-flight credits, FIFO occupancy/pointers and the error flag.
    always_comb begin
        inflight_d = inflight_q;
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        err_d      = err_q;

        if (inflight_inc && !inflight_dec) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (inflight_dec && !inflight_inc) begin
            inflight_d = inflight_q - CNT_W'(1);
        end

        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        if (push) begin
            wptr_d = ptr_inc(wptr_q);
        end
        if (pop) begin
            rptr_d = ptr_inc(rptr_q);
        end

        // Done and tag pipeline disagree: the product cannot be attributed, drop it.
        if (mult_done_i != head_vld) begin
            err_d = 1'b1;
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            inflight_q <= '0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            err_q      <= err_d;
        end
    end

    // Tag pipeline shifts every cycle, tracking the multiplier stage by stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_vld_q <= '0;
        end else begin
            tag_vld_q[0] <= accept;
            tag_q[0]     <= req_tag_i;
            for (int i = 1; i < int'(STAGES); i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_q[i]     <= tag_q[i-1];
            end
        end
    end

    // FIFO payload storage; contents are meaningless until counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wptr_q] <= mult_product_i;
            tag_mem[wptr_q]  <= head_tag;
        end
    end

endmodule

// File: tb/tb_mult_retire_q.sv
// Self-checking bench for mult_retire_q with a behavioural fixed-latency multiplier and an
// in-order scoreboard that predicts readiness, response timing and payloads.
module tb_mult_retire_q;

    localparam int BW = 32;
    localparam int ST = 3;
    localparam int TW = 5;
    localparam int DP = 4;
`ifdef MULT_RETIRE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [BW-1:0] req_a_i = '0;
    logic [BW-1:0] req_b_i = '0;
    logic [TW-1:0] req_tag_i = '0;
    logic          mult_en_o;
    logic [BW-1:0] mult_a_o;
    logic [BW-1:0] mult_b_o;
    logic [BW-1:0] mult_product_i;
    logic          mult_done_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [BW-1:0] rsp_data_o;
    logic [TW-1:0] rsp_tag_o;
    logic          err_o;
    logic          fault_done = 1'b0;

    always #5 clk = ~clk;

    mult_retire_q #(
        .BIT_WIDTH(BW),
        .STAGES   (ST),
        .TAG_W    (TW),
        .DEPTH    (DP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_a_i       (req_a_i),
        .req_b_i       (req_b_i),
        .req_tag_i     (req_tag_i),
        .mult_en_o     (mult_en_o),
        .mult_a_o      (mult_a_o),
        .mult_b_o      (mult_b_o),
        .mult_product_i(mult_product_i),
        .mult_done_i   (mult_done_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_data_o    (rsp_data_o),
        .rsp_tag_o     (rsp_tag_o),
        .err_o         (err_o)
    );

    // Behavioural pipe_mult: enable sampled at an edge, done/product ST edges later.
    logic [ST-1:0] pm_vld;
    logic [BW-1:0] pm_prod [ST];
    always @(posedge clk) begin
        if (!rst) begin
            pm_vld <= '0;
        end else begin
            pm_vld[0]  <= mult_en_o;
            pm_prod[0] <= mult_a_o * mult_b_o;
            for (int i = 1; i < ST; i++) begin
                pm_vld[i]  <= pm_vld[i-1];
                pm_prod[i] <= pm_prod[i-1];
            end
        end
    end
    assign mult_done_i    = pm_vld[ST-1] | fault_done;
    assign mult_product_i = pm_prod[ST-1];

    typedef struct {
        logic [BW-1:0] d;
        logic [TW-1:0] t;
        int            acc;
    } item_t;

    item_t         sb_q[$];
    logic [TW-1:0] pop_tags[$];
    logic [BW-1:0] last_data;
    logic [TW-1:0] last_tag;
    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;
    int            acc_cnt = 0;
    int            rsp_cnt = 0;
    logic          exp_err = 1'b0;
    logic          nxt_rst = 1'b0;
    logic          nxt_fault = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive at the falling edge, predict, compare, update the model.
    task automatic step(input logic v, input logic [BW-1:0] a, input logic [BW-1:0] b,
                        input logic [TW-1:0] t, input logic rr);
        logic  exp_vld;
        logic  exp_rdy;
        item_t it;
        @(negedge clk);
        rst         = nxt_rst;
        fault_done  = nxt_fault;
        req_valid_i = v;
        req_a_i     = a;
        req_b_i     = b;
        req_tag_i   = t;
        rsp_ready_i = rr;
        #1;
        // Oldest outstanding result is presentable STAGES+1 cycles after acceptance,
        // or one cycle earlier when it can be bypassed straight to a ready consumer.
        exp_vld = 1'b0;
        if (rst && sb_q.size() != 0) begin
            if (cyc >= sb_q[0].acc + ST + 1) begin
                exp_vld = 1'b1;
            end else if (BYP && rr && cyc == sb_q[0].acc + ST) begin
                exp_vld = 1'b1;
            end
        end
        exp_rdy = rst && ((sb_q.size() - ((exp_vld && rr) ? 1 : 0)) < DP);

        check_eq("req_ready", {63'd0, req_ready_o}, {63'd0, exp_rdy});
        check_eq("rsp_valid", {63'd0, rsp_valid_o}, {63'd0, exp_vld});
        check_eq("mult_en", {63'd0, mult_en_o}, {63'd0, v && exp_rdy});
        check_eq("err", {63'd0, err_o}, {63'd0, rst ? exp_err : 1'b0});
        check_eq("mult_a", {32'd0, mult_a_o}, {32'd0, a});
        check_eq("mult_b", {32'd0, mult_b_o}, {32'd0, b});

        if (exp_vld && rr) begin
            if (rsp_valid_o) begin
                check_eq("rsp_data", {32'd0, rsp_data_o}, {32'd0, sb_q[0].d});
                check_eq("rsp_tag", {59'd0, rsp_tag_o}, {59'd0, sb_q[0].t});
            end
            last_data = rsp_data_o;
            last_tag  = rsp_tag_o;
            pop_tags.push_back(rsp_tag_o);
            rsp_cnt++;
            void'(sb_q.pop_front());
        end
        if (v && exp_rdy) begin
            it.d   = a * b;
            it.t   = t;
            it.acc = cyc;
            sb_q.push_back(it);
            acc_cnt++;
        end
        if (!rst) begin
            sb_q.delete();
            exp_err = 1'b0;
        end
        cyc++;
    endtask

    task automatic idle(input int n, input logic rr);
        repeat (n) step(1'b0, '0, '0, '0, rr);
    endtask

    function automatic logic [BW-1:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return BW'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int drops;

        // Reset held with a request offered: nothing accepted, nothing presented.
        repeat (3) step(1'b1, 32'd2, 32'd3, 5'd5, 1'b1);
        nxt_rst = 1'b1;
        idle(2, 1'b1);

        // Single operation.
        rsp_cnt = 0;
        step(1'b1, 32'd2, 32'd3, 5'd5, 1'b1);
        idle(8, 1'b1);
        check_eq("single_cnt", 64'(rsp_cnt), 64'd1);
        check_eq("single_data", {32'd0, last_data}, 64'd6);
        check_eq("single_tag", {59'd0, last_tag}, 64'd5);

        // Products wrap to the low BIT_WIDTH bits.
        step(1'b1, 32'hFFFF_FFFF, 32'd3, 5'd1, 1'b1);
        idle(8, 1'b1);
        check_eq("wrap_data", {32'd0, last_data}, 64'hFFFF_FFFD);
        step(1'b1, 32'hFFFF_FFEC, 32'd5, 5'd2, 1'b1);
        idle(8, 1'b1);
        check_eq("neg_data", {32'd0, last_data}, 64'hFFFF_FF9C);

        // Backpressure: exactly DEPTH accepted, then drained in tag order.
        acc_cnt = 0;
        pop_tags.delete();
        for (int i = 0; i < 12; i++) begin
            step(1'b1, rand_op(), rand_op(), TW'(acc_cnt), 1'b0);
        end
        check_eq("bp_accepts", 64'(acc_cnt), 64'(DP));
        idle(10, 1'b1);
        check_eq("bp_drained", 64'(pop_tags.size()), 64'(DP));
        for (int i = 0; i < DP; i++) begin
            if (i < pop_tags.size()) begin
                check_eq("bp_order", {59'd0, pop_tags[i]}, 64'(i));
            end
        end
        check_eq("bp_ready_back", {63'd0, req_ready_o}, 64'd1);

        // Reset with one result buffered and three in flight.
        step(1'b1, rand_op(), rand_op(), 5'd10, 1'b0);
        idle(ST, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, rand_op(), rand_op(), TW'(11 + i), 1'b0);
        end
        rsp_cnt = 0;
        nxt_rst = 1'b0;
        idle(1, 1'b1);
        nxt_rst = 1'b1;
        idle(10, 1'b1);
        check_eq("reset_no_rsp", 64'(rsp_cnt), 64'd0);
        check_eq("reset_ready", {63'd0, req_ready_o}, 64'd1);

        // Stray done with nothing in flight: sticky error, FIFO untouched.
        nxt_fault = 1'b1;
        idle(1, 1'b1);
        nxt_fault = 1'b0;
        exp_err = 1'b1;
        idle(5, 1'b1);
        check_eq("fault_sticky", {63'd0, err_o}, 64'd1);
        nxt_rst = 1'b0;
        idle(1, 1'b1);
        nxt_rst = 1'b1;
        idle(2, 1'b1);

        // Streaming with DEPTH = STAGES+1: full throughput.
        drops = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, rand_op(), rand_op(), TW'(i), 1'b1);
            if (!req_ready_o) drops++;
        end
        idle(8, 1'b1);
        check_eq("stream_drops", 64'(drops), 64'd0);

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), rand_op(), rand_op(), TW'($urandom()),
                 1'($urandom_range(0, 3) != 0));
        end
        idle(12, 1'b1);
        check_eq("final_empty", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
